// File: rtl/tx_pad_ctrl_pkg.sv
// Shared definitions for the transmit pad/framing stage: length defaults,
// FSM state encoding, and lane helper functions.
package tx_pad_ctrl_pkg;

    localparam int MIN_LEN_DEFAULT = 60;
    localparam int MAX_LEN_DEFAULT = 1514;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        GAP  = 2'd3
    } state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'd0, v[i]};
        end
        return sum;
    endfunction

    // n lanes starting at lane 0; anything of 8 or more saturates to a full word.
    function automatic logic [7:0] laneMask(input logic [3:0] n);
        if (n >= 4'd8) begin
            return 8'hFF;
        end
        return 8'((9'd1 << n) - 9'd1);
    endfunction

    function automatic logic [63:0] maskData(input logic [63:0] data, input logic [7:0] mask);
        logic [63:0] res;
        res = data;
        for (int i = 0; i < 8; i++) begin
            if (!mask[i]) begin
                res[i*8 +: 8] = 8'h00;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tx_pad_ctrl.sv
// Frames client words for the MAC transmit path: measures each frame from the
// external byte counter and zero-pads runt frames up to the minimum length.
module tx_pad_ctrl
    import tx_pad_ctrl_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEFAULT,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TX_SOF,
    input  logic        TX_EOF,
    input  logic [63:0] TX_DATA,
    input  logic [7:0]  TX_VALID,
    output logic        TX_READY,
    input  logic [15:0] BYTE_COUNTER,
    output logic        COUNT_START,
    output logic [63:0] PAD_DATA,
    output logic [7:0]  PAD_VALID,
    output logic        PAD_SOF,
    output logic        PAD_EOF,
    output logic [15:0] FRAME_LEN,
    output logic        PADDED,
    output logic        OVERSIZE
);

    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_base;
    logic [15:0] w_base_nxt;
    logic [15:0] r_pe;
    logic [15:0] w_pe_nxt;

    logic [63:0] r_pad_data;
    logic [7:0]  r_pad_valid;
    logic        r_pad_sof;
    logic        r_pad_eof;
    logic [15:0] r_frame_len;
    logic        r_padded;
    logic        r_oversize;

    logic [63:0] w_data_nxt;
    logic [7:0]  w_valid_nxt;
    logic        w_sof_nxt;
    logic        w_eof_nxt;
    logic [15:0] w_len_nxt;
    logic        w_padded_nxt;
    logic        w_oversize_nxt;

    logic        w_ready;
    logic        w_take;
    logic [15:0] w_base;
    logic [15:0] w_e;
    logic [16:0] w_e8;
    logic [15:0] w_l;
    logic [16:0] w_pe8;

    assign w_ready     = !RESET && (r_state == IDLE || r_state == DATA);
    assign w_take      = w_ready && (TX_VALID != 8'h00) &&
                         ((r_state == IDLE && TX_SOF) || r_state == DATA);
    assign TX_READY    = w_ready;
    assign COUNT_START = w_take && !TX_EOF;

    // On a SOF&EOF word the base is captured in the same cycle, so E is 0.
    assign w_base = (r_state == IDLE) ? BYTE_COUNTER : r_base;
    assign w_e    = BYTE_COUNTER - w_base;
    assign w_e8   = {1'b0, w_e} + 17'd8;
    assign w_l    = w_e + {12'd0, popcount8(TX_VALID)};
    assign w_pe8  = {1'b0, r_pe} + 17'd8;

    always_comb begin
        w_state_nxt    = r_state;
        w_base_nxt     = r_base;
        w_pe_nxt       = r_pe;
        w_data_nxt     = 64'd0;
        w_valid_nxt    = 8'h00;
        w_sof_nxt      = 1'b0;
        w_eof_nxt      = 1'b0;
        w_len_nxt      = 16'd0;
        w_padded_nxt   = 1'b0;
        w_oversize_nxt = 1'b0;

        case (r_state)
            IDLE, DATA: begin
                if (w_take) begin
                    w_sof_nxt = (r_state == IDLE);
                    if (r_state == IDLE) begin
                        w_base_nxt = BYTE_COUNTER;
                    end
                    if (!TX_EOF) begin
                        w_data_nxt  = TX_DATA;
                        w_valid_nxt = 8'hFF;
                        w_state_nxt = DATA;
                    end else if (w_l >= MIN_L) begin
                        w_data_nxt     = TX_DATA;
                        w_valid_nxt    = TX_VALID;
                        w_eof_nxt      = 1'b1;
                        w_len_nxt      = w_l;
                        w_oversize_nxt = (w_l > MAX_L);
                        w_state_nxt    = GAP;
                    end else if (w_e8 >= {1'b0, MIN_L}) begin
                        w_data_nxt   = maskData(TX_DATA, TX_VALID);
                        w_valid_nxt  = laneMask(4'(MIN_L - w_e));
                        w_eof_nxt    = 1'b1;
                        w_len_nxt    = MIN_L;
                        w_padded_nxt = 1'b1;
                        w_state_nxt  = GAP;
                    end else begin
                        w_data_nxt  = maskData(TX_DATA, TX_VALID);
                        w_valid_nxt = 8'hFF;
                        w_pe_nxt    = w_e8[15:0];
                        w_state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                if (w_pe8 < {1'b0, MIN_L}) begin
                    w_valid_nxt = 8'hFF;
                    w_pe_nxt    = w_pe8[15:0];
                end else begin
                    w_valid_nxt  = laneMask(4'(MIN_L - r_pe));
                    w_eof_nxt    = 1'b1;
                    w_len_nxt    = MIN_L;
                    w_padded_nxt = 1'b1;
                    w_state_nxt  = GAP;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A reset mid-frame drops the partial frame; no closing EOF is produced.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_base      <= 16'd0;
            r_pe        <= 16'd0;
            r_pad_data  <= 64'd0;
            r_pad_valid <= 8'h00;
            r_pad_sof   <= 1'b0;
            r_pad_eof   <= 1'b0;
            r_frame_len <= 16'd0;
            r_padded    <= 1'b0;
            r_oversize  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_pe        <= w_pe_nxt;
            r_pad_data  <= w_data_nxt;
            r_pad_valid <= w_valid_nxt;
            r_pad_sof   <= w_sof_nxt;
            r_pad_eof   <= w_eof_nxt;
            r_frame_len <= w_len_nxt;
            r_padded    <= w_padded_nxt;
            r_oversize  <= w_oversize_nxt;
        end
    end

    assign PAD_DATA  = r_pad_data;
    assign PAD_VALID = r_pad_valid;
    assign PAD_SOF   = r_pad_sof;
    assign PAD_EOF   = r_pad_eof;
    assign FRAME_LEN = r_frame_len;
    assign PADDED    = r_padded;
    assign OVERSIZE  = r_oversize;

endmodule

// File: doc/tx_pad_ctrl.md
# tx_pad_ctrl

Transmit-path stage that frames client words for the 10G MAC transmit engine. It drives the count enable of the byte counter and reads the counter's running total back. From that total it computes each frame's length and zero-pads runt frames to the Ethernet minimum before FCS insertion. Its output feeds the FCS/encoder stage.

## Interface
Parameters:
- MIN_LEN, 60: minimum frame bytes excluding FCS; pad target.
- MAX_LEN, 1514: maximum legal frame bytes excluding FCS.

Ports:
- CLK  in  1  transmit clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset; same reset as the byte counter.
- TX_SOF  in  1  first word of frame.
- TX_EOF  in  1  last word of frame; may coincide with TX_SOF.
- TX_DATA  in  64  client data, byte 0 in [7:0].
- TX_VALID  in  8  lane valid mask, contiguous from lane 0; 0 = no word.
- TX_READY  out  1  word accepted when TX_READY=1 and TX_VALID≠0.
- BYTE_COUNTER  in  16  running total from the byte counter (+8 per enabled cycle, wraps mod 2^16).
- COUNT_START  out  1  combinational enable to the counter: 1 on each accepted non-EOF word.
- PAD_DATA  out  64  framed data, pad bytes = 8'h00.
- PAD_VALID  out  8  output lane mask.
- PAD_SOF / PAD_EOF  out  1 each  output frame delimiters.
- FRAME_LEN  out  16  final length incl. padding, excl. FCS; valid with PAD_EOF.
- PADDED  out  1  1 with PAD_EOF if padding was added.
- OVERSIZE  out  1  1 with PAD_EOF if unpadded length > MAX_LEN.

## Operation
- States: IDLE, DATA, PAD, GAP.
- IDLE:
  - A word with TX_SOF is accepted, and BASE <= BYTE_COUNTER is captured.
  - A word without SOF is dropped; TX_READY stays 1.
  - With SOF&EOF, handle the word as EOF directly.
- DATA: accept words. A SOF seen in DATA is ignored, and the word is treated as a continuation.
- Non-EOF words: mask treated as 8'hFF; COUNT_START=1.
- On the EOF word:
  - E = (BYTE_COUNTER − BASE) mod 2^16 = bytes before this word.
  - p = popcount(TX_VALID).
  - L = E + p.
- If L ≥ MIN_LEN:
  - Emit the word as-is with PAD_EOF and FRAME_LEN=L.
  - OVERSIZE = (L > MAX_LEN).
  - Go to GAP.
- If L < MIN_LEN and E+8 ≥ MIN_LEN:
  - Emit the word with mask extended to (MIN_LEN−E) lanes, new lanes zeroed.
  - PAD_EOF; PADDED=1; FRAME_LEN=MIN_LEN.
  - Go to GAP.
- Otherwise:
  - Emit the word with mask 8'hFF, lanes ≥p zeroed, no EOF.
  - Set PE=E+8 and go to PAD.
- PAD:
  - TX_READY=0; emit all-zero words.
  - While PE+8 < MIN_LEN: mask 8'hFF, PE += 8.
  - Final word: mask = MIN_LEN−PE lanes, PAD_EOF, PADDED=1, FRAME_LEN=MIN_LEN.
  - Then go to GAP.
- GAP: one cycle, TX_READY=0, no output word, then go to IDLE.
- Reset, including mid-frame:
  - State IDLE, BASE=0, PE=0.
  - All outputs 0, except TX_READY=0 while RESET is asserted and 1 thereafter.
  - The partial frame is discarded with no PAD_EOF.

## Timing
- PAD_* outputs, FRAME_LEN, PADDED and OVERSIZE are registered: 1 cycle latency from the accepting edge.
- COUNT_START and TX_READY are combinational from state and inputs.
- The counter is registered, so BYTE_COUNTER seen in a cycle reflects all COUNT_START pulses before that cycle. E therefore excludes the EOF word.
- Counter wrap: subtraction is mod 2^16, so a frame spanning the 16'hFFF8→16'h0000 wrap yields the correct L.
- Idle with no valid input produces PAD_VALID=0 and all strobes 0.
- TX_READY is 0 for (pad words) + 1 GAP cycles after an EOF acceptance.
- Back-to-back frames: the next SOF is accepted the cycle after GAP.

## Structure
- Shared tx package holds:
  - MIN_LEN/MAX_LEN defaults.
  - State encoding: IDLE=0, DATA=1, PAD=2, GAP=3.
  - An 8-bit popcount function.
  - Mask-from-count function: n lanes → (1<<n)−1, 8 → 8'hFF.
- No sub-module: popcount and mask generation are package functions. The byte counter stays a separate instance wired at the top level.

## Test plan
- 64-byte frame, BYTE_COUNTER starting 16'h0100 → COUNT_START pulses 7 times; FRAME_LEN=64; PADDED=0; outputs equal inputs.
- Single word SOF&EOF, TX_VALID=8'h03 → 8 output words:
  - First word mask FF, lanes 2–7 zero.
  - 6 zero FF words.
  - Final mask 8'h0F with PAD_EOF; FRAME_LEN=60; TX_READY low 8 cycles.
- 7 full words + EOF word with TX_VALID=8'h01 (L=57) → EOF word mask 8'h0F, PADDED=1, FRAME_LEN=60, no PAD state.
- 1515-byte frame with BASE=16'hFC00 (wraps) → FRAME_LEN=1515, OVERSIZE=1.
- RESET asserted in the third word of a frame → all outputs 0 next edge, no PAD_EOF. The next SOF frame after release is processed normally from BASE=0.
- Word without SOF in IDLE → dropped, no COUNT_START, no output.
